// File: rtl/sysx_pkg.sv
// Shared sysX definitions: transaction states, status-byte layout, internal ID register.
// Bus-side vectors use [0:N] numbering, so bit 0 is the most significant bit.
package sysx_pkg;

  typedef enum logic [2:0] {
    sIdle     = 3'd0,
    sCommand  = 3'd1,
    sHighHigh = 3'd2,
    sHigh     = 3'd3,
    sLow      = 3'd4,
    sLowLow   = 3'd5,
    sEnd      = 3'd6
  } tState;

  localparam logic [0:6] cInternalAddr     = 7'h7F;
  localparam logic [0:7] cIdHigh           = 8'h53;
  localparam logic [0:7] cIdLow            = 8'h58;
  localparam int         cStatusPresentBit = 0;
  localparam int         cStatusPendingBit = 7;

  function automatic logic [0:7] statusByte(input logic pending);
    logic [0:7] status;
    status                    = '0;
    status[cStatusPresentBit] = 1'b1;
    status[cStatusPendingBit] = pending;
    return status;
  endfunction

  function automatic logic [0:31] internalWord(input logic pending);
    return {cIdHigh, cIdLow, 15'h0000, pending};
  endfunction

  // Successor of a data-byte state; sLowLow is handled by the caller.
  function automatic tState nextDataState(input tState state);
    tState next;
    case (state)
      sHighHigh: next = sHigh;
      sHigh:     next = sLow;
      sLow:      next = sLowLow;
      default:   next = sEnd;
    endcase
    return next;
  endfunction

endpackage

// File: rtl/sysx_sync.sv
// Multi-flop synchronizer for asynchronous bus inputs, with per-bit rise/fall pulses
// derived from the synchronized value (pulses last one iClock cycle).
module sysx_sync #(
  parameter int pWidth  = 1,
  parameter int pStages = 2
) (
  input  logic              iClock,
  input  logic              iReset,
  input  logic [pWidth-1:0] iAsync,
  output logic [pWidth-1:0] oSync,
  output logic [pWidth-1:0] oRise,
  output logic [pWidth-1:0] oFall
);

  logic [pWidth-1:0] stages [pStages];
  logic [pWidth-1:0] prev;

  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      for (int i = 0; i < pStages; i++) stages[i] <= '0;
      prev <= '0;
    end else begin
      stages[0] <= iAsync;
      for (int i = 1; i < pStages; i++) stages[i] <= stages[i-1];
      prev <= stages[pStages-1];
    end
  end

  assign oSync = stages[pStages-1];
  assign oRise = oSync & ~prev;
  assign oFall = ~oSync & prev;

endmodule

// File: rtl/sysx_slave.sv
// sysX v1 slave endpoint: decodes 5-byte bus transactions (command + 4 data bytes)
// into single-cycle local register reads/writes and raises the bus interrupt.
module sysx_slave
  import sysx_pkg::*;
#(
  parameter logic [1:0] pAddress    = 2'd1,
  parameter int         pSyncStages = 2
) (
  input  logic        iClock,
  input  logic        iReset,
  input  logic        iBusClock,
  input  logic [1:0]  iBusSelect,
  input  logic [0:7]  iBusMOSI,
  output logic [0:7]  oBusMISO,
  output logic        oBusMISOEnable,
  output logic        oBusInterrupt,
  output logic [0:6]  oRegAddr,
  output logic [0:31] oRegWData,
  output logic        oRegWrite,
  output logic        oRegRead,
  input  logic [0:31] iRegRData,
  input  logic        iIrq,
  output tState       oDebugState
);

  logic        busClkSync, busRise, busFall;
  logic [1:0]  selSync, selRise, selFall;
  logic [0:7]  mosiSync, mosiRise, mosiFall;
  logic        unusedEdges;

  sysx_sync #(.pWidth(1), .pStages(pSyncStages)) uClockSync (
    .iClock (iClock),
    .iReset (iReset),
    .iAsync (iBusClock),
    .oSync  (busClkSync),
    .oRise  (busRise),
    .oFall  (busFall)
  );

  sysx_sync #(.pWidth(2), .pStages(pSyncStages)) uSelectSync (
    .iClock (iClock),
    .iReset (iReset),
    .iAsync (iBusSelect),
    .oSync  (selSync),
    .oRise  (selRise),
    .oFall  (selFall)
  );

  sysx_sync #(.pWidth(8), .pStages(pSyncStages)) uMosiSync (
    .iClock (iClock),
    .iReset (iReset),
    .iAsync (iBusMOSI),
    .oSync  (mosiSync),
    .oRise  (mosiRise),
    .oFall  (mosiFall)
  );

  assign unusedEdges = ^{busClkSync, selRise, selFall, mosiRise, mosiFall};

  tState       state;
  logic        selected;
  logic        isWrite;
  logic        isInternal;
  logic [0:31] shiftReg;
  logic [0:31] accum;
  logic        pending;
  logic        irqPrev;
  logic        irqSet;
  logic        irqClear;

  assign selected       = (selSync == pAddress);
  assign oBusMISOEnable = selected;
  assign oBusInterrupt  = pending;
  assign oDebugState    = state;

  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      state      <= sIdle;
      oBusMISO   <= '0;
      oRegAddr   <= '0;
      oRegWData  <= '0;
      oRegWrite  <= 1'b0;
      oRegRead   <= 1'b0;
      isWrite    <= 1'b0;
      isInternal <= 1'b0;
      shiftReg   <= '0;
      accum      <= '0;
    end else begin
      oRegWrite <= 1'b0;
      oRegRead  <= 1'b0;
      // Local read data is valid exactly one cycle after the read strobe.
      if (oRegRead) shiftReg <= iRegRData;

      if (!selected) begin
        state    <= sIdle;
        oBusMISO <= '0;
      end else begin
        case (state)
          sIdle: begin
            state    <= sCommand;
            oBusMISO <= statusByte(pending);
          end
          sCommand: begin
            // No falling edge precedes the command byte, so status is kept live here.
            oBusMISO <= statusByte(pending);
            if (busRise) begin
              state      <= sHighHigh;
              isWrite    <= mosiSync[0];
              isInternal <= (mosiSync[1:7] == cInternalAddr);
              if (mosiSync[1:7] != cInternalAddr) begin
                oRegAddr <= mosiSync[1:7];
                oRegRead <= ~mosiSync[0];
              end else if (!mosiSync[0]) begin
                shiftReg <= internalWord(pending);
              end
            end
          end
          sHighHigh, sHigh, sLow, sLowLow: begin
            if (busFall) begin
              oBusMISO <= isWrite ? 8'h00 : shiftReg[0:7];
              shiftReg <= {shiftReg[8:31], 8'h00};
            end
            if (busRise) begin
              accum <= {accum[8:31], mosiSync};
              if (state == sLowLow) begin
                state <= sEnd;
                if (isWrite && !isInternal) begin
                  oRegWrite <= 1'b1;
                  oRegWData <= {accum[8:31], mosiSync};
                end
              end else begin
                state <= nextDataState(state);
              end
            end
          end
          sEnd: begin
            state <= sEnd;
          end
          default: begin
            state <= sIdle;
          end
        endcase
      end
    end
  end

  // Reading the internal register acknowledges the interrupt; a new edge in the same cycle wins.
  assign irqSet   = iIrq & ~irqPrev;
  assign irqClear = selected && busRise && (state == sLowLow) && isInternal && !isWrite;

  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      irqPrev <= 1'b0;
      pending <= 1'b0;
    end else begin
      irqPrev <= iIrq;
      if (irqSet) pending <= 1'b1;
      else if (irqClear) pending <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sysx_slave.sv
// Bench for sysx_slave: a bus-master driver, a local register-file model and
// scoreboards for MISO bytes, write strobes and read strobes.
module tb_sysx_slave;
  import sysx_pkg::*;

  localparam int HALF = 6;
  localparam int SYNC = 2;

  logic        iClock = 1'b0;
  logic        iReset;
  logic        iBusClock;
  logic [1:0]  iBusSelect;
  logic [7:0]  iBusMOSI;
  logic [7:0]  oBusMISO;
  logic        oBusMISOEnable;
  logic        oBusInterrupt;
  logic [6:0]  oRegAddr;
  logic [31:0] oRegWData;
  logic        oRegWrite;
  logic        oRegRead;
  logic [31:0] iRegRData;
  logic        iIrq;
  tState       oDebugState;

  sysx_slave #(.pAddress(2'd1), .pSyncStages(SYNC)) dut (
    .iClock         (iClock),
    .iReset         (iReset),
    .iBusClock      (iBusClock),
    .iBusSelect     (iBusSelect),
    .iBusMOSI       (iBusMOSI),
    .oBusMISO       (oBusMISO),
    .oBusMISOEnable (oBusMISOEnable),
    .oBusInterrupt  (oBusInterrupt),
    .oRegAddr       (oRegAddr),
    .oRegWData      (oRegWData),
    .oRegWrite      (oRegWrite),
    .oRegRead       (oRegRead),
    .iRegRData      (iRegRData),
    .iIrq           (iIrq),
    .oDebugState    (oDebugState)
  );

  always #5 iClock = ~iClock;

  int          nChecks = 0;
  int          nPass   = 0;
  int          nWrites = 0;
  int          nReads  = 0;
  int          nUnexp  = 0;
  logic        expPending = 1'b0;
  logic [31:0] regMem [128];
  logic [7:0]  exp_q [$];
  logic [38:0] wr_q [$];
  logic [6:0]  rd_q [$];

  task automatic check(input string tag, input logic [39:0] got, input logic [39:0] exp);
    nChecks++;
    if (got === exp) nPass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge iClock);
  endtask

  task automatic checkResetOutputs();
    check("rst_miso", oBusMISO, 8'h00);
    check("rst_miso_en", oBusMISOEnable, 1'b0);
    check("rst_irq", oBusInterrupt, 1'b0);
    check("rst_addr", oRegAddr, 7'h00);
    check("rst_wdata", oRegWData, 32'h0);
    check("rst_strobes", {oRegWrite, oRegRead}, 2'b00);
    check("rst_state", oDebugState, sIdle);
  endtask

  // Local register file: records strobes and answers reads one cycle after oRegRead.
  always @(negedge iClock) begin
    if (!iReset) begin
      if (oRegWrite) begin
        nWrites++;
        if (wr_q.size() == 0) nUnexp++;
        else begin
          logic [38:0] e;
          e = wr_q.pop_front();
          check("wr_addr", oRegAddr, e[38:32]);
          check("wr_data", oRegWData, e[31:0]);
        end
      end
      if (oRegRead) begin
        nReads++;
        if (rd_q.size() == 0) nUnexp++;
        else check("rd_addr", oRegAddr, rd_q.pop_front());
        iRegRData = regMem[oRegAddr];
      end else begin
        iRegRData = $urandom();
      end
    end
  end

  // One master transaction: nRise bytes, then deselect (or reset when doReset).
  task automatic busXfer(input logic [1:0] sel, input logic [39:0] frame, input int nRise,
                         input bit doReset, input bit irqOnClear);
    logic [7:0]  cmd;
    logic [6:0]  addr;
    logic [31:0] rd;
    logic        isWr, hit, internal;
    cmd      = frame[39:32];
    isWr     = cmd[7];
    addr     = cmd[6:0];
    hit      = (sel == 2'd1);
    internal = (addr == 7'h7F);
    rd       = internal ? {8'h53, 8'h58, 15'h0, expPending} : regMem[addr];
    if (hit && !isWr && !internal) rd_q.push_back(addr);
    iBusSelect = sel;
    for (int k = 0; k < nRise; k++) begin
      iBusMOSI = frame[39-8*k -: 8];
      if (!hit) exp_q.push_back(8'h00);
      else if (k == 0) exp_q.push_back({1'b1, 6'b0, expPending});
      else if (isWr) exp_q.push_back(8'h00);
      else exp_q.push_back(rd[39-8*k -: 8]);
      if (k == 4 && hit && isWr && !internal) begin
        wr_q.push_back({addr, frame[31:0]});
        regMem[addr] = frame[31:0];
      end
      waitCycles(HALF);
      check("miso_en", oBusMISOEnable, hit);
      check("miso", oBusMISO, exp_q.pop_front());
      iBusClock = 1'b1;
      if (k == 4 && irqOnClear) begin
        waitCycles(SYNC);
        iIrq = 1'b1;
        waitCycles(1);
        iIrq = 1'b0;
        waitCycles(HALF - SYNC - 1);
      end else begin
        waitCycles(HALF);
      end
      iBusClock = 1'b0;
    end
    if (nRise == 5 && hit && !isWr && internal && !irqOnClear) expPending = 1'b0;
    if (doReset) begin
      iReset     = 1'b1;
      iBusSelect = 2'd0;
      iBusMOSI   = 8'h00;
      waitCycles(2);
      checkResetOutputs();
      iReset     = 1'b0;
      expPending = 1'b0;
    end else begin
      waitCycles(HALF);
      iBusSelect = 2'd0;
      iBusMOSI   = 8'h00;
    end
    waitCycles(HALF);
    check("end_state", oDebugState, sIdle);
  endtask

  task automatic pulseIrq();
    iIrq = 1'b1;
    waitCycles(1);
    iIrq = 1'b0;
    expPending = 1'b1;
    waitCycles(2);
    check("irq_set", oBusInterrupt, 1'b1);
  endtask

  initial begin
    int w0, r0;
    logic [6:0]  a;
    logic [31:0] d;
    for (int i = 0; i < 128; i++) regMem[i] = 32'h0;
    regMem[6]  = 32'h12345678;
    iReset     = 1'b1;
    iBusClock  = 1'b0;
    iBusSelect = 2'd0;
    iBusMOSI   = 8'h00;
    iRegRData  = 32'h0;
    iIrq       = 1'b0;
    waitCycles(3);
    checkResetOutputs();
    iReset = 1'b0;
    waitCycles(2);

    // Reset after the HighHigh byte of a write: no strobe, then a clean write.
    w0 = nWrites;
    busXfer(2'd1, {8'h85, 32'hCAFEF00D}, 2, 1'b1, 1'b0);
    check("rst_abort_wr", nWrites - w0, 0);
    busXfer(2'd1, {8'h85, 32'hDEADBEEF}, 5, 1'b0, 1'b0);
    check("wr_count", nWrites - w0, 1);
    check("hold_addr", oRegAddr, 7'h05);
    check("hold_wdata", oRegWData, 32'hDEADBEEF);

    // Read of register 6.
    r0 = nReads;
    busXfer(2'd1, {8'h06, 32'h0}, 5, 1'b0, 1'b0);
    check("rd_count", nReads - r0, 1);

    // Traffic addressed to another slave.
    w0 = nWrites;
    r0 = nReads;
    busXfer(2'd2, {8'h85, 32'h11223344}, 5, 1'b0, 1'b0);
    busXfer(2'd2, {8'h06, 32'h0}, 5, 1'b0, 1'b0);
    check("other_sel_strobes", (nWrites - w0) + (nReads - r0), 0);

    // Interrupt, status byte and internal ID register read-to-clear.
    pulseIrq();
    r0 = nReads;
    busXfer(2'd1, {8'h7F, 32'h0}, 5, 1'b0, 1'b0);
    check("id_no_rd", nReads - r0, 0);
    check("irq_cleared", oBusInterrupt, 1'b0);
    pulseIrq();
    busXfer(2'd1, {8'h7F, 32'h0}, 5, 1'b0, 1'b1);
    check("irq_set_wins", oBusInterrupt, 1'b1);
    busXfer(2'd1, {8'h7F, 32'h0}, 5, 1'b0, 1'b0);
    check("irq_cleared2", oBusInterrupt, 1'b0);

    // Deselect after the High byte of a write, then reads still correct.
    w0 = nWrites;
    busXfer(2'd1, {8'h8A, 32'h99887766}, 3, 1'b0, 1'b0);
    busXfer(2'd1, {8'hFF, 32'h01020304}, 5, 1'b0, 1'b0);
    check("abort_wr", nWrites - w0, 0);
    busXfer(2'd1, {8'h06, 32'h0}, 5, 1'b0, 1'b0);
    busXfer(2'd1, {8'h05, 32'h0}, 5, 1'b0, 1'b0);

    // Random write/read-back pairs.
    for (int i = 0; i < 4; i++) begin
      a = 7'($urandom_range(0, 126));
      d = $urandom();
      busXfer(2'd1, {1'b1, a, d}, 5, 1'b0, 1'b0);
      busXfer(2'd1, {1'b0, a, 32'h0}, 5, 1'b0, 1'b0);
    end

    waitCycles(4);
    check("wr_q_empty", wr_q.size(), 0);
    check("rd_q_empty", rd_q.size(), 0);
    check("unexpected_strobes", nUnexp, 0);
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
